// File: rtl/mlacc_mem_xbar.sv
// mlacc_mem_xbar
//   Data-memory crossbar between the accelerator controller/datapath and
//   NUM_BANK single-cycle-latency dual-port bank RAMs.
//   - Port A of each bank serves the X/Y operand reads. If X and Y hit
//     different words of the same bank, the read is split over two cycles
//     and counted in out_conflict_cnt.
//   - Port B of each bank receives the Z writeback. It is never stalled.
//
// Ports
//   in_clk, in_reset        clock, synchronous active-high reset
//   in_req_valid / out_req_ready   X/Y read request handshake
//   in_addr_x, in_addr_y    operand byte addresses
//   out_rd_valid, out_X, out_Y     operand data, one-cycle valid pulse
//   in_we, in_addr_z, in_Z  Z write strobe, byte address, data
//   out_bank_a_addr         per-bank port A read address
//   in_bank_a_rdata         per-bank port A read data (1-cycle latency)
//   out_bank_b_we/addr/wdata       per-bank port B write controls
//   out_conflict_cnt        saturating count of split requests
module mlacc_mem_xbar #(
    parameter int DATA_W   = 128,
    parameter int NUM_BANK = 4,
    parameter int BANK_AW  = 14,
    parameter int BYTE_OFS = 4
) (
    input  logic                         in_clk,
    input  logic                         in_reset,
    input  logic                         in_req_valid,
    output logic                         out_req_ready,
    input  logic [31:0]                  in_addr_x,
    input  logic [31:0]                  in_addr_y,
    output logic                         out_rd_valid,
    output logic [DATA_W-1:0]            out_X,
    output logic [DATA_W-1:0]            out_Y,
    input  logic                         in_we,
    input  logic [31:0]                  in_addr_z,
    input  logic [DATA_W-1:0]            in_Z,
    output logic [NUM_BANK*BANK_AW-1:0]  out_bank_a_addr,
    input  logic [NUM_BANK*DATA_W-1:0]   in_bank_a_rdata,
    output logic [NUM_BANK-1:0]          out_bank_b_we,
    output logic [NUM_BANK*BANK_AW-1:0]  out_bank_b_addr,
    output logic [NUM_BANK*DATA_W-1:0]   out_bank_b_wdata,
    output logic [31:0]                  out_conflict_cnt
);

    localparam int BANK_BITS = $clog2(NUM_BANK);

    typedef enum logic {IDLE, SPLIT} state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    state_t                 state;
    logic [BANK_BITS-1:0]   bank_x, bank_y, bank_z;
    logic [BANK_AW-1:0]     word_x, word_y, word_z;
    logic                   accept, same_bank, same_word, conflict;

    assign bank_x = in_addr_x[31 -: BANK_BITS];
    assign bank_y = in_addr_y[31 -: BANK_BITS];
    assign bank_z = in_addr_z[31 -: BANK_BITS];
    assign word_x = in_addr_x[BANK_AW-1+BYTE_OFS:BYTE_OFS];
    assign word_y = in_addr_y[BANK_AW-1+BYTE_OFS:BYTE_OFS];
    assign word_z = in_addr_z[BANK_AW-1+BYTE_OFS:BYTE_OFS];

    // Address bits outside bank/word fields are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{in_addr_x, in_addr_y, in_addr_z};

    assign out_req_ready = (state == IDLE);
    assign accept        = in_req_valid & out_req_ready;
    assign same_bank     = (bank_x == bank_y);
    assign same_word     = (word_x == word_y);
    assign conflict      = same_bank & ~same_word;

    logic [DATA_W-1:0]    rdata [NUM_BANK];
    logic [BANK_AW-1:0]   a_addr [NUM_BANK];
    logic [BANK_AW-1:0]   a_addr_q [NUM_BANK];

    // Latched second half of a split request.
    logic [BANK_BITS-1:0] split_bank_p0;
    logic [BANK_AW-1:0]   split_word_p0;

    // Read-return stage: bank selects, hold register and valid.
    logic [BANK_BITS-1:0] sel_x_p1, sel_y_p1;
    logic                 from_hold_p1;
    logic [DATA_W-1:0]    hold_x_p1;
    logic                 vld_p1;
    logic [31:0]          conflict_cnt;

    for (genvar k = 0; k < NUM_BANK; k++) begin : g_bank
        assign rdata[k] = in_bank_a_rdata[k*DATA_W +: DATA_W];
        assign out_bank_a_addr[k*BANK_AW +: BANK_AW]  = a_addr[k];
        assign out_bank_b_addr[k*BANK_AW +: BANK_AW]  = word_z;
        assign out_bank_b_wdata[k*DATA_W +: DATA_W]   = in_Z;
        assign out_bank_b_we[k] = in_we & ~in_reset & (bank_z == BANK_BITS'(k));
    end

    // Port A steering; banks without a new request keep their last address.
    always_comb begin
        a_addr = a_addr_q;
        if (state == SPLIT) begin
            a_addr[split_bank_p0] = split_word_p0;
        end else if (accept) begin
            // Covers both the same-word case and the first half of a split.
            a_addr[bank_x] = word_x;
            if (!same_bank) begin
                a_addr[bank_y] = word_y;
            end
        end
    end

    // ---- request stage -> read-return stage ----
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state        <= IDLE;
            vld_p1       <= 1'b0;
            from_hold_p1 <= 1'b0;
            hold_x_p1    <= '0;
            conflict_cnt <= '0;
        end else begin
            from_hold_p1 <= (state == SPLIT);
            vld_p1       <= (state == SPLIT) | (accept & ~conflict);
            if (state == SPLIT) begin
                // Bank now returns the X word read in the accept cycle.
                hold_x_p1 <= rdata[split_bank_p0];
                state     <= IDLE;
            end else if (accept && conflict) begin
                state        <= SPLIT;
                conflict_cnt <= sat_inc(conflict_cnt);
            end
        end
    end

    always_ff @(posedge in_clk) begin
        a_addr_q <= a_addr;
        if (accept) begin
            sel_x_p1      <= bank_x;
            sel_y_p1      <= bank_y;
            split_bank_p0 <= bank_y;
            split_word_p0 <= word_y;
        end
    end

    assign out_rd_valid     = vld_p1;
    assign out_X            = from_hold_p1 ? hold_x_p1 : rdata[sel_x_p1];
    assign out_Y            = rdata[sel_y_p1];
    assign out_conflict_cnt = conflict_cnt;

endmodule

// File: doc/mlacc_mem_xbar.md
# mlacc_mem_xbar

Parametrised data-memory crossbar for the ML accelerator: routes the controller's X/Y operand reads and Z writeback across `NUM_BANK` single-cycle-latency dual-port data RAMs, replacing the fixed two-bank steering done at top level. Detects X/Y read conflicts on the same bank, serialises them over two cycles with a ready/valid handshake, and counts conflicts for debug. It sits between `mlacc_ctrl`/`mlacc_datapath` and the bank RAM instances.

## Interface

Parameters:
- `DATA_W`, 128, bank word width (one vector)
- `NUM_BANK`, 4, number of banks; power of two, ≥2
- `BANK_AW`, 14, word-address width per bank
- `BYTE_OFS`, 4, byte-offset bits dropped from 32-bit addresses

Ports. One clock; reset is synchronous and active-high. Clock `in_clk`, reset `in_reset`.
- `in_clk`  in  1  clock
- `in_reset`  in  1  synchronous active-high reset
- `in_req_valid`  in  1  X/Y read request
- `out_req_ready`  out  1  request accepted when valid&ready
- `in_addr_x`, `in_addr_y`  in  32  byte addresses of operands
- `out_rd_valid`  out  1  X/Y data valid (one-cycle pulse)
- `out_X`, `out_Y`  out  DATA_W  operand data
- `in_we`  in  1  Z write strobe
- `in_addr_z`  in  32  Z byte address
- `in_Z`  in  DATA_W  Z write data
- `out_bank_a_addr`  out  NUM_BANK*BANK_AW  per-bank read address (port A)
- `in_bank_a_rdata`  in  NUM_BANK*DATA_W  per-bank read data, one-cycle latency
- `out_bank_b_we`  out  NUM_BANK  per-bank write enable (port B)
- `out_bank_b_addr`  out  NUM_BANK*BANK_AW  per-bank write address
- `out_bank_b_wdata`  out  NUM_BANK*DATA_W  per-bank write data (Z broadcast)
- `out_conflict_cnt`  out  32  saturating count of split requests

## Operation

- Bank index = `addr[31 -: log2(NUM_BANK)]`; word index = `addr[BANK_AW-1+BYTE_OFS:BYTE_OFS]`. Remaining bits ignored.
- FSM states: IDLE, SPLIT. `out_req_ready` = (state==IDLE).
- IDLE, request accepted:
  - banks differ: drive both bank A addresses; stay IDLE.
  - same bank, same word: one read; X and Y both receive that word; no conflict.
  - same bank, different word: drive X word; latch Y bank/word; go to SPLIT; increment `out_conflict_cnt` (saturates at 0xFFFFFFFF).
- SPLIT: drive latched Y word on that bank; capture X data into hold register; return to IDLE.
- Output mux: registered bank selects pick `out_X`/`out_Y` from `in_bank_a_rdata`; after a split, `out_X` comes from the hold register.
- Idle banks hold their last address (no toggling requirement); unused data ignored.
- Writes: independent of the read FSM, never stalled. `out_bank_b_we[k]` = `in_we` & (Z bank==k); address/data broadcast to all banks. Read/write to the same word in the same cycle returns the bank's configured mode data; no forwarding is performed (controller owns RAW ordering).

## Timing

- Non-conflict request accepted at cycle T -> `out_rd_valid`=1 at T+1 with X/Y. Back-to-back requests every cycle.
- Conflict accepted at T -> ready=0 at T+1 -> `out_rd_valid`=1 at T+2; ready=1 again at T+2 (new request acceptable at T+2).
- `out_X`/`out_Y` valid only while `out_rd_valid`=1; undefined otherwise.
- Request inputs need only be valid at acceptance cycle.
- Reset values: state IDLE, `out_req_ready`=1 after the reset cycle, `out_rd_valid`=0, hold register 0, `out_conflict_cnt`=0, `out_bank_b_we`=0 while `in_reset`=1 (writes suppressed during reset).
- Reset asserted in SPLIT: abandon; no `out_rd_valid` pulse for the pending request; also suppresses a pending T+1 pulse.
- Request with `in_req_valid`=1 during SPLIT is not accepted and must be held by the source.

## Test plan

- NUM_BANK=4: X=0x0000_0010 (bank0 word1), Y=0x4000_0020 (bank1 word2) -> rd_valid at T+1, X=bank0[1], Y=bank1[2], ready stays 1, conflict_cnt=0.
- Same bank, different words: X=0x8000_0000, Y=0x8000_0030 -> ready=0 at T+1, rd_valid only at T+2 with X=bank2[0], Y=bank2[3], conflict_cnt=1.
- Same bank, same word: X=Y=0xC000_0040 -> rd_valid at T+1, X==Y==bank3[4], conflict_cnt=0.
- Write routing: in_we=1, addr_z=0x4000_0050, Z=0xDEAD… -> only out_bank_b_we[1]=1, addr=5; simultaneous split read unaffected; in_reset=1 with in_we=1 -> all we=0.
- Reset mid-SPLIT: conflict accepted at T, in_reset=1 at T+1 -> no rd_valid at T+2, state IDLE, conflict_cnt=0, ready=1 after reset released.
- Back-to-back 8 non-conflict requests -> 8 consecutive rd_valid pulses, data matching per-request banks; preload conflict_cnt near saturation (force) -> holds at 0xFFFFFFFF.
